// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI byte stream to framed multi-byte register bank with read-back
module spi_reg_bank #(
    parameter  int NUM_REGS   = 16,
    parameter  int DATA_BYTES = 2,
    localparam int ADDR_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int REG_W      = 8 * DATA_BYTES
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    input  logic                      csn,
    output logic [7:0]                send_byte,
    output logic [NUM_REGS*REG_W-1:0] regs,
    output logic                      wr_pulse,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic                      frame_err,
    output logic                      busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA,
        S_DRAIN
    } state_t;

    localparam int                IDX_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DATA_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [7:0]        NUM_REGS_B = 8'(NUM_REGS);
    localparam logic [7:0]        CMD_MARK   = 8'hA5;

    logic              csn_s1_q, csn_s2_q, csn_s3_q;
    logic              sync_live_q;
    logic              armed_q;
    logic              frame_start, frame_end;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [REG_W-1:0]  asm_q, asm_d;
    logic [7:0]        send_q, send_d;
    logic              wr_pulse_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              frame_err_q, frame_err_d;
    logic              commit;
    logic [ADDR_W-1:0] addr_inc;
    logic [REG_W-1:0]  regs_q [NUM_REGS];

    // csn synchronizer; the bank only arms once a genuinely sampled high csn has been seen,
    // so a csn still held low across reset release never looks like a new frame start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csn_s1_q    <= 1'b1;
            csn_s2_q    <= 1'b1;
            csn_s3_q    <= 1'b1;
            sync_live_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            csn_s1_q    <= csn;
            csn_s2_q    <= csn_s1_q;
            csn_s3_q    <= csn_s2_q;
            sync_live_q <= 1'b1;
            if (sync_live_q && csn_s1_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign frame_start = armed_q & csn_s3_q & ~csn_s2_q;
    assign frame_end   = ~csn_s3_q & csn_s2_q;
    assign addr_inc    = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

    // Next-state decode: command, write assembly, read advance, frame end and reply byte
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        commit      = 1'b0;
        frame_err_d = 1'b0;
        send_d      = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (byte_valid) begin
                    if ({1'b0, byte_in[6:0]} >= NUM_REGS_B) begin
                        state_d     = S_DRAIN;
                        frame_err_d = 1'b1;
                    end else begin
                        addr_d  = byte_in[ADDR_W-1:0];
                        idx_d   = '0;
                        state_d = byte_in[7] ? S_RDATA : S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (byte_valid) begin
                    asm_d = REG_W'({asm_q, byte_in});
                    if (idx_q == LAST_IDX) begin
                        commit = 1'b1;
                        addr_d = addr_inc;
                        idx_d  = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_RDATA: begin
                if (byte_valid) begin
                    if (idx_q == LAST_IDX) begin
                        addr_d = addr_inc;
                        idx_d  = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A byte landing with the frame-end edge is processed first; only a leftover partial word errs
        if (frame_end && state_q != S_IDLE) begin
            if (state_q == S_WDATA && idx_d != '0) begin
                frame_err_d = 1'b1;
            end
            state_d = S_IDLE;
        end

        if (state_d == S_CMD) begin
            send_d = CMD_MARK;
        end else if (state_d == S_RDATA) begin
            send_d = 8'(regs_q[addr_d] >> (8 * (DATA_BYTES - 1 - int'(idx_d))));
        end
    end

    // Control state and registered strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            send_q      <= 8'h00;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            send_q      <= send_d;
            wr_pulse_q  <= commit;
            frame_err_q <= frame_err_d;
            if (commit) begin
                wr_addr_q <= addr_q;
            end
        end
    end

    // Register array; a completed word lands at the address it was started on
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[addr_q] <= asm_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*REG_W +: REG_W] = regs_q[g];
    end

    assign send_byte = send_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - bench for spi_reg_bank with a frame-level reference model
module tb_spi_reg_bank;

    localparam int NR = 16;
    localparam int DB = 2;
    localparam int RW = 8 * DB;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [7:0]       byte_in = 8'h00;
    logic             byte_valid = 1'b0;
    logic             csn = 1'b1;
    logic [7:0]       send_byte;
    logic [NR*RW-1:0] regs;
    logic             wr_pulse;
    logic [3:0]       wr_addr;
    logic             frame_err;
    logic             busy;

    always #5 clk = ~clk;

    spi_reg_bank #(.NUM_REGS(NR), .DATA_BYTES(DB)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .csn        (csn),
        .send_byte  (send_byte),
        .regs       (regs),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // reference model state (written only by the stimulus process)
    logic [RW-1:0] m_regs [NR];
    bit            m_active, m_rd, m_drain;
    int            m_n, m_start;
    logic [RW-1:0] m_buf;
    bit            e_wr, e_err, e_busy;
    logic [3:0]    e_wr_addr;
    logic [7:0]    e_send;
    bit            chk_en = 1'b0;

    // literal-check handoff to the compare process
    int            lit_seq = 0;
    string         lit_name;
    logic [31:0]   lit_act, lit_exp;

    // owned by the compare process
    int            checks = 0;
    int            fails = 0;
    int            lit_seen = 0;
    int            wr_cnt = 0;
    int            err_cnt = 0;
    logic [NR*RW-1:0] m_flat;

    task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NR; i++) m_flat[i*RW +: RW] = m_regs[i];
            cmp("regs", 256'(regs), 256'(m_flat));
            cmp("wr_pulse", 256'(wr_pulse), 256'(e_wr));
            cmp("wr_addr", 256'(wr_addr), 256'(e_wr_addr));
            cmp("frame_err", 256'(frame_err), 256'(e_err));
            cmp("busy", 256'(busy), 256'(e_busy));
            cmp("send_byte", 256'(send_byte), 256'(e_send));
            if (wr_pulse) wr_cnt++;
            if (frame_err) err_cnt++;
        end
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            cmp(lit_name, 256'(lit_act), 256'(lit_exp));
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lit_name = nm;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] rd_byte(input int m);
        int            a, pos;
        logic [RW-1:0] w;
        a   = (m_start + m / DB) % NR;
        pos = m % DB;
        w   = m_regs[a];
        return 8'(w >> (8 * (DB - 1 - pos)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_active = 0; m_rd = 0; m_drain = 0; m_n = 0; m_start = 0; m_buf = '0;
        e_wr = 0; e_err = 0; e_busy = 0; e_wr_addr = '0; e_send = 8'h00;
    endtask

    // n-th byte of the frame: byte 0 is the command, the rest are data bytes j = n-1
    task automatic model_byte(input logic [7:0] b);
        int j, a;
        if (!m_active) return;
        if (m_n == 0) begin
            if (int'(b[6:0]) >= NR) begin
                m_drain = 1; e_err = 1; e_send = 8'h00;
            end else begin
                m_start = int'(b[6:0]);
                m_rd    = b[7];
                e_send  = m_rd ? rd_byte(0) : 8'h00;
            end
        end else if (!m_drain) begin
            j = m_n - 1;
            a = (m_start + j / DB) % NR;
            if (!m_rd) begin
                m_buf = {m_buf[7:0], b};
                if (j % DB == DB - 1) begin
                    m_regs[a] = m_buf;
                    e_wr      = 1;
                    e_wr_addr = 4'(a);
                end
            end else begin
                e_send = rd_byte(m_n);
            end
        end
        m_n++;
    endtask

    task automatic model_end();
        if (m_active && !m_drain && !m_rd && m_n >= 1 && (m_n - 1) % DB != 0) e_err = 1;
        m_active = 0; e_busy = 0; e_send = 8'h00;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        byte_valid = 1'b0;
        e_wr  = 0;
        e_err = 0;
    endtask

    task automatic put(input logic [7:0] b);
        cyc();
        byte_in = b; byte_valid = 1'b1;
        cyc();
        model_byte(b);
        cyc();
        cyc();
    endtask

    task automatic frame_begin();
        cyc();
        csn = 1'b0;
        cyc(); cyc(); cyc();
        m_active = 1; m_n = 0; m_drain = 0; m_rd = 0;
        e_busy = 1; e_send = 8'hA5;
    endtask

    task automatic frame_stop();
        cyc();
        csn = 1'b1;
        cyc(); cyc(); cyc();
        model_end();
        cyc(); cyc();
    endtask

    task automatic frame_stop_with_byte(input logic [7:0] b);
        cyc();
        csn = 1'b1;
        cyc(); cyc();
        byte_in = b; byte_valid = 1'b1;
        cyc();
        model_byte(b);
        model_end();
        cyc(); cyc();
    endtask

    logic [NR*RW-1:0] snap;

    initial begin
        model_reset();
        rstn = 1'b0;
        cyc(); cyc();
        chk_en = 1'b1;
        cyc();
        lit("rst_send", 32'(send_byte), 32'h00);
        lit("rst_busy", 32'(busy), 32'h0);
        lit("rst_regs_zero", 32'(regs == '0), 32'h1);
        rstn = 1'b1;
        repeat (4) cyc();

        // single write
        frame_begin();
        put(8'h03); put(8'h12); put(8'h34);
        frame_stop();
        lit("w1_reg3", 32'(regs[3*RW +: RW]), 32'h1234);
        lit("w1_wr_cnt", 32'(wr_cnt), 32'd1);
        lit("w1_wr_addr", 32'(wr_addr), 32'd3);
        snap = regs; snap[3*RW +: RW] = '0;
        lit("w1_others_zero", 32'(snap == '0), 32'h1);

        // burst with wrap-around
        frame_begin();
        put(8'h0F); put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
        frame_stop();
        lit("burst_reg15", 32'(regs[15*RW +: RW]), 32'hAABB);
        lit("burst_reg0", 32'(regs[0 +: RW]), 32'hCCDD);
        lit("burst_wr_cnt", 32'(wr_cnt), 32'd3);

        // read-back
        frame_begin();
        lit("rd_send_cmd", 32'(send_byte), 32'hA5);
        put(8'h83);
        lit("rd_send_b0", 32'(send_byte), 32'h12);
        put(8'h00);
        lit("rd_send_b1", 32'(send_byte), 32'h34);
        put(8'h00);
        frame_stop();
        lit("rd_no_write", 32'(wr_cnt), 32'd3);

        // bad address
        snap = regs;
        frame_begin();
        put(8'h20); put(8'h11); put(8'h22);
        frame_stop();
        lit("bad_err_cnt", 32'(err_cnt), 32'd1);
        lit("bad_regs_same", 32'(regs == snap), 32'h1);

        // short frame
        frame_begin();
        put(8'h05); put(8'h99);
        frame_stop();
        lit("short_err_cnt", 32'(err_cnt), 32'd2);
        lit("short_reg5", 32'(regs[5*RW +: RW]), 32'h0);

        // last byte coincides with frame-end edge
        frame_begin();
        put(8'h06); put(8'hAB);
        frame_stop_with_byte(8'hCD);
        lit("edge_reg6", 32'(regs[6*RW +: RW]), 32'hABCD);
        lit("edge_err_cnt", 32'(err_cnt), 32'd2);
        lit("edge_wr_cnt", 32'(wr_cnt), 32'd4);

        // reset mid-frame, csn held low across release
        frame_begin();
        put(8'h02); put(8'h77);
        cyc();
        rstn = 1'b0;
        model_reset();
        cyc(); cyc();
        lit("mid_rst_regs", 32'(regs == '0), 32'h1);
        lit("mid_rst_busy", 32'(busy), 32'h0);
        rstn = 1'b1;
        repeat (6) cyc();
        lit("post_rst_idle", 32'(busy), 32'h0);
        csn = 1'b1;
        repeat (5) cyc();
        frame_begin();
        put(8'h02); put(8'h55); put(8'h66);
        frame_stop();
        lit("post_rst_reg2", 32'(regs[2*RW +: RW]), 32'h5566);
        lit("post_rst_wr_addr", 32'(wr_addr), 32'd2);

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

SPI-fed register bank. It turns the per-byte output of `spi_slave` into framed register-write and register-read transactions over a parametrised array of multi-byte registers. Bursts auto-increment the address, and the block produces the reply byte for MISO read-back. It sits between `spi_slave` and the synth/LED logic in `top`, and replaces the direct latching of `recv` into `led_val`.

## Interface
Parameters:
- `NUM_REGS`, 16: number of registers, 1..128. `ADDR_W = max(1, $clog2(NUM_REGS))`.
- `DATA_BYTES`, 2: bytes per register, 1..4. `REG_W = 8*DATA_BYTES`.

Ports:
- `clk` input 1: system clock, 100 MHz.
- `rstn` input 1: reset, asynchronous, active-low.
- `byte_in` input 8: received byte, driven by `spi_slave.recv`.
- `byte_valid` input 1: one-cycle pulse in the `clk` domain that qualifies `byte_in`, driven by `spi_slave.output_valid`.
- `csn` input 1: raw SPI chip select, asynchronous; low means a frame is active.
- `send_byte` output 8: reply byte, drives `spi_slave.send`.
- `regs` output `NUM_REGS*REG_W`: flattened register contents; register i occupies `[i*REG_W +: REG_W]`.
- `wr_pulse` output 1: one-cycle strobe on each committed write.
- `wr_addr` output `ADDR_W`: address of the last committed write.
- `frame_err` output 1: one-cycle pulse when a frame error is detected.
- `busy` output 1: high while a frame is active.

## Operation
- `csn` passes through a 2-flop synchronizer. Frame start is a synced falling edge; frame end is a synced rising edge.
- Command byte, the first `byte_valid` after frame start:
  - bit7 = R/W, where 1 means read.
  - bits[6:0] = start address.
- State machine states: IDLE, CMD, WDATA, RDATA, DRAIN.
  - IDLE -> CMD on frame start.
  - CMD + `byte_valid`:
    - address ≥ `NUM_REGS`: go to DRAIN and pulse `frame_err`.
    - otherwise: latch `addr`, clear `byte_idx`, go to WDATA (write) or RDATA (read).
  - WDATA + `byte_valid`: shift `byte_in` into the assembly register, MSB byte first, and increment `byte_idx`. When `byte_idx == DATA_BYTES-1`:
    - write the assembled word to `regs[addr]`;
    - pulse `wr_pulse` and set `wr_addr = addr`;
    - set `addr = (addr == NUM_REGS-1) ? 0 : addr+1` (burst wrap-around);
    - clear `byte_idx`.
  - RDATA + `byte_valid`: the received byte is ignored. Advance `byte_idx`/`addr` with the same increment and wrap rules as writes.
  - DRAIN: discard all bytes.
  - Frame end from any state -> IDLE.
- Partial writes:
  - If a frame ends in WDATA with `byte_idx != 0`, the partial word is discarded, no write occurs, and `frame_err` pulses.
  - A partial read is not an error.
- Reply byte:
  - `send_byte` = byte `byte_idx` (MSB first) of `regs[addr]` while in RDATA.
  - `send_byte = 8'h00` in all other states.
  - In CMD, `send_byte = 8'hA5` (status marker returned during the command byte).
- Same-cycle write and read-back: a write and a read of the same register in one cycle cannot occur, because one frame is one direction.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - state IDLE, `regs` all 0, `send_byte` 8'h00, `wr_pulse` 0, `wr_addr` 0, `frame_err` 0, `busy` 0.
  - Synchronizer flops reset to 1, so no frame is active after reset.
- Frame start/end detection: 3 `clk` cycles after `csn` changes (2 sync stages plus 1 edge register).
- Write commit: `regs` and `wr_pulse` update on the clock edge after the `byte_valid` of the last data byte. `wr_pulse` is high for exactly 1 cycle.
- `send_byte` is registered. It updates 1 cycle after the `byte_valid` that advances `byte_idx`/`addr`, and 1 cycle after the CMD decode. This is well before the next SPI byte starts at any SCLK ≤ 10 MHz.
- `byte_valid` in the same cycle as the synced frame-end edge: the byte is processed first, including a possible write commit, and the state then returns to IDLE. A completed word in that cycle is not an error.
- `byte_valid` while in IDLE (no frame) is ignored.
- Reset asserted mid-frame: everything clears immediately and any partial word is lost. After reset releases, the block waits for a new falling edge of `csn`.
- `frame_err` and `wr_pulse` never assert in the same cycle.

## Test plan
- Write, `NUM_REGS`=16, `DATA_BYTES`=2. Frame: `0x03, 0x12, 0x34`.
  - Required: `regs[3]`=16'h1234, exactly one `wr_pulse` with `wr_addr`=3, all other registers 0.
- Burst with wrap. Frame: `0x0F`, then `0xAA, 0xBB, 0xCC, 0xDD`.
  - Required: `regs[15]`=16'hAABB, `regs[0]`=16'hCCDD, two `wr_pulse`s.
- Read-back after the first test. Frame: `0x83`, then 2 dummy bytes.
  - Required: `send_byte` sequence `0xA5`, `0x12`, `0x34`; no `wr_pulse`.
- Bad address. Frame: `0x20, 0x11, 0x22`.
  - Required: one `frame_err` pulse, `regs` unchanged.
- Short frame. Frame: `0x05, 0x99`, then `csn` rises.
  - Required: `frame_err` pulses, `regs[5]` unchanged. A last data byte arriving in the same cycle as the frame-end edge still commits.
- Reset mid-frame. Assert `rstn`=0 after `0x02, 0x77`.
  - Required: all outputs at reset values. A later full frame writes correctly.
